mp3_stream_fifo: RTL



---
 rtl/mp3_fifo_pkg.sv | 18 +
 rtl/mp3_fifo_ram.sv | 26 ++
 rtl/mp3_stream_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mp3_fifo_pkg.sv
// Shared types and default constants for the MP3 bitstream FIFO.
// Statistics ports are enabled by defining MP3_FIFO_STATS_EN.
package mp3_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } fifo_state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DEPTH   = 512;
    localparam int DEF_LOW_WM  = DEF_DEPTH / 4;
    localparam int DEF_HIGH_WM = 3 * DEF_DEPTH / 4;

    localparam logic [15:0] UNDERRUN_SAT = 16'hFFFF;

endpackage

// File: rtl/mp3_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Kept standalone so a vendor RAM wrapper can be dropped in.
module mp3_fifo_ram #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mp3_stream_fifo.sv
// First-word-fall-through bitstream FIFO feeding the decoder read port.
// Define MP3_FIFO_STATS_EN to add underrun_cnt / overflow statistics.
//
// state  | meaning
// IDLE   | no stream in progress
// STREAM | stream open, writes accepted
// DRAIN  | tagged last word stored, writes refused until it is read
module mp3_stream_fifo
    import mp3_fifo_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LOW_WM  = DEPTH / 4,
    parameter int HIGH_WM = 3 * DEPTH / 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = AW + 1
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_full,
    output logic              fill_req,
    input  logic              fifo_ren,
    output logic [DATA_W-1:0] fifo_datain,
    output logic              fifo_valid,
    output logic              fifo_last,
    output logic              stream_done,
`ifdef MP3_FIFO_STATS_EN
    output logic [15:0]       underrun_cnt,
    output logic              overflow,
`endif
    output logic [LW-1:0]     level
);

    localparam logic [LW-1:0] LOW_LVL  = LW'(LOW_WM);
    localparam logic [LW-1:0] HIGH_LVL = LW'(HIGH_WM);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    fifo_state_e       state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic              full_q, full_d, fill_q, fill_d, done_q, done_d;
    logic              wr_acc, rd_eff;
    logic [DATA_W:0]   ram_rdata;

    mp3_fifo_ram #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_ram (
        .clk   (CLK_I),
        .we    (wr_acc & ~flush),
        .waddr (wr_ptr_q),
        .wdata ({wr_last, wr_data}),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_acc   = wr_en & ~full_q & (state_q != DRAIN);
        rd_eff   = fifo_ren & valid_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_eff ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(wr_acc) - LW'(rd_eff);
        state_d  = state_q;
        done_d   = rd_eff & last_q & (state_q == DRAIN);
        data_d   = data_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;

        if (wr_acc && wr_last) begin
            state_d = DRAIN;
        end else if (wr_acc && state_q == IDLE) begin
            state_d = STREAM;
        end else if (done_d) begin
            state_d = IDLE;
        end

        // When the new head is the word being written this edge, bypass the RAM.
        if (level_d != '0) begin
            valid_d = 1'b1;
            if (wr_acc && rd_ptr_d == wr_ptr_q) begin
                {last_d, data_d} = {wr_last, wr_data};
            end else begin
                {last_d, data_d} = ram_rdata;
            end
        end

        full_d = (level_d == FULL_LVL);
        if (state_d == DRAIN) begin
            fill_d = 1'b0;
        end else if (level_d <= LOW_LVL) begin
            fill_d = 1'b1;
        end else if (level_d >= HIGH_LVL) begin
            fill_d = 1'b0;
        end else begin
            fill_d = fill_q;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            state_d  = IDLE;
            done_d   = 1'b0;
            data_d   = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            full_d   = 1'b0;
            fill_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            full_q   <= 1'b0;
            fill_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            full_q   <= full_d;
            fill_q   <= fill_d;
            done_q   <= done_d;
        end
    end

    assign wr_full     = full_q;
    assign fill_req    = fill_q;
    assign fifo_datain = data_q;
    assign fifo_valid  = valid_q;
    assign fifo_last   = last_q;
    assign stream_done = done_q;
    assign level       = level_q;

`ifdef MP3_FIFO_STATS_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;
    logic        overflow_q, overflow_d;

    // Statistics survive flush; only RST_I clears them.
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (!flush && fifo_ren && !valid_q && underrun_cnt_q != UNDERRUN_SAT) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
        overflow_d = overflow_q | (~flush & wr_en & ~wr_acc);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            underrun_cnt_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
            overflow_q     <= overflow_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
    assign overflow     = overflow_q;
`endif

endmodule
